// File: rtl/score_ctrl_if.sv
// Purpose: bundles the game-control inputs and the score/display outputs of score_ctrl.
// Signals:
//   tick       - one-clk-wide game-tick pulse
//   start      - level, player requests a new game
//   death      - level, player has collided
//   win        - level, level completed
//   state      - FSM state (IDLE=0, RUN=1, OVER=2, WON=3)
//   score_bcd  - current score, two BCD digits
//   hi_bcd     - high score, two BCD digits
//   disp_bcd   - value shown on the seven-segment pair
//   disp_blank - display blank request
//   new_hi     - last finished game set a new high score
// Modports: master drives the game inputs, slave (score_ctrl) drives the outputs.
interface score_ctrl_if;
  logic       tick;
  logic       start;
  logic       death;
  logic       win;
  logic [1:0] state;
  logic [7:0] score_bcd;
  logic [7:0] hi_bcd;
  logic [7:0] disp_bcd;
  logic       disp_blank;
  logic       new_hi;

  modport master (
    output tick, start, death, win,
    input  state, score_bcd, hi_bcd, disp_bcd, disp_blank, new_hi
  );

  modport slave (
    input  tick, start, death, win,
    output state, score_bcd, hi_bcd, disp_bcd, disp_blank, new_hi
  );
endinterface

// File: rtl/score_ctrl.sv
// Purpose: game score controller. Tracks a saturating two-digit BCD score during a
// game, keeps the high score, selects what the display shows and blinks the display
// after a game that set a new high score.
// Ports:
//   clk   - system clock, all state changes on its rising edge
//   reset - synchronous active-high reset (also clears the high score)
//   bus   - score_ctrl_if.slave: tick/start/death/win in; state, score_bcd, hi_bcd,
//           disp_bcd, disp_blank, new_hi out (registered or decoded from registers)
module score_ctrl #(
  parameter int unsigned BLINK_TICKS = 12,
  parameter logic [7:0]  SAT_SCORE   = 8'h99
) (
  input  logic         clk,
  input  logic         reset,
  score_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2,
    ST_WON  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_score;
  logic [7:0]       r_hi;
  logic             r_new_hi;
  logic             r_blank;
  logic [CNT_W-1:0] r_blink_cnt;

  logic [7:0]       w_score_inc;
  logic             w_ended;
  logic             w_new_game;
  logic             w_game_end;
  logic             w_run_tick;
  logic             w_blink_tick;

  // Qualified events; start wins over everything outside RUN, death/win win over tick in RUN.
  always_comb begin
    w_ended      = (r_state == ST_OVER) || (r_state == ST_WON);
    w_new_game   = bus.start && (r_state != ST_RUN);
    w_game_end   = (r_state == ST_RUN) && (bus.death || bus.win);
    w_run_tick   = (r_state == ST_RUN) && bus.tick && !bus.death && !bus.win;
    w_blink_tick = w_ended && r_new_hi && bus.tick && !bus.start;
  end

  // Saturating BCD increment; digits never exceed 9.
  always_comb begin
    w_score_inc = r_score;
    if (r_score != SAT_SCORE) begin
      if (r_score[3:0] >= 4'd9) begin
        w_score_inc[3:0] = 4'd0;
        w_score_inc[7:4] = (r_score[7:4] >= 4'd9) ? 4'd0 : (r_score[7:4] + 4'd1);
      end else begin
        w_score_inc[3:0] = r_score[3:0] + 4'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.death)    w_state_nxt = ST_OVER;
        else if (bus.win) w_state_nxt = ST_WON;
      end
      ST_OVER,
      ST_WON:  if (bus.start) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Score, high score and blink registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_score     <= 8'h00;
      r_hi        <= 8'h00;
      r_new_hi    <= 1'b0;
      r_blank     <= 1'b0;
      r_blink_cnt <= '0;
    end else if (w_new_game) begin
      r_score     <= 8'h00;
      r_new_hi    <= 1'b0;
      r_blank     <= 1'b0;
      r_blink_cnt <= '0;
    end else if (w_game_end) begin
      // Compare uses the score as it stood before this edge.
      if (r_score > r_hi) begin
        r_hi     <= r_score;
        r_new_hi <= 1'b1;
      end else begin
        r_new_hi <= 1'b0;
      end
    end else if (w_run_tick) begin
      r_score <= w_score_inc;
    end else if (w_blink_tick) begin
      if (r_blink_cnt == CNT_LAST) begin
        r_blink_cnt <= '0;
        r_blank     <= ~r_blank;
      end else begin
        r_blink_cnt <= r_blink_cnt + CNT_W'(1);
      end
    end
  end

  // Outputs, decoded from registers only.
  always_comb begin
    bus.state      = r_state;
    bus.score_bcd  = r_score;
    bus.hi_bcd     = r_hi;
    bus.new_hi     = r_new_hi;
    bus.disp_blank = r_blank;
    bus.disp_bcd   = (r_state == ST_IDLE) ? r_hi : r_score;
  end

endmodule
